// File: rtl/fp_align_shifter.sv
// Exponent-alignment stage for the FP add/sub path: picks the larger-exponent operand
// and right-shifts the other mantissa STEP bits per cycle, collecting guard/round/sticky.
module fp_align_shifter #(
    parameter int STEP = 4,
    parameter int SAT  = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  exp_a,
    input  logic [23:0] man_a,
    input  logic [7:0]  exp_b,
    input  logic [23:0] man_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  exp_out,
    output logic [23:0] man_big,
    output logic [26:0] man_small,
    output logic        swapped,
    output logic [7:0]  shift_amt
);

    localparam logic [7:0] SAT8  = 8'(SAT);
    localparam logic [4:0] SAT5  = 5'(SAT);
    localparam logic [4:0] STEP5 = 5'(STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_next;
    logic [4:0]  remaining;
    logic        accept;
    logic        a_big;
    logic [7:0]  diff;
    logic [4:0]  rem_init;
    logic [4:0]  k_amt;
    logic [26:0] shifted;
    logic [26:0] lost_mask;
    logic        lost;
    logic [26:0] shift_next;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Ties go to A, so swapped only flags a strictly larger B exponent.
    assign a_big    = (exp_a >= exp_b);
    assign diff     = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
    assign rem_init = (diff >= SAT8) ? SAT5 : diff[4:0];

    // Bits shifted out this cycle (including the old sticky) fold into the new sticky.
    always_comb begin
        k_amt      = (remaining < STEP5) ? remaining : STEP5;
        shifted    = man_small >> k_amt;
        lost_mask  = (27'd1 << k_amt) - 27'd1;
        lost       = |(man_small & lost_mask);
        shift_next = {shifted[26:1], shifted[0] | lost};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (rem_init == 5'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (remaining == k_amt) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_out   <= 8'd0;
            man_big   <= 24'd0;
            man_small <= 27'd0;
            swapped   <= 1'b0;
            shift_amt <= 8'd0;
            remaining <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        swapped   <= !a_big;
                        exp_out   <= a_big ? exp_a : exp_b;
                        man_big   <= a_big ? man_a : man_b;
                        man_small <= a_big ? {man_b, 3'b000} : {man_a, 3'b000};
                        shift_amt <= diff;
                        remaining <= rem_init;
                    end
                end
                SHIFT: begin
                    man_small <= shift_next;
                    remaining <= remaining - k_amt;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/fp_align_shifter.md
Name: fp_align_shifter

Overview:
- Sequential exponent-alignment stage at the front of the floating-point add/sub path.
- Accepts two unpacked single-precision operands (8-bit exponent, 24-bit mantissa with hidden bit) and selects the larger-exponent operand.
- Shifts the smaller mantissa right by the exponent difference, STEP bits per cycle, and produces guard/round/sticky bits.
- This is the inverse of leading-zero normalisation: a shift amount turns into a denormalised mantissa, where normalisation turns a mantissa into a shift count.

Parameters:
- STEP, 4, maximum right-shift distance applied per SHIFT cycle (legal 1..27).
- SAT, 27, shift saturation limit; at or above this distance all mantissa bits end up in sticky.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- exp_a  in  8  exponent of operand A
- man_a  in  24  mantissa of operand A, hidden bit at [23]
- exp_b  in  8  exponent of operand B
- man_b  in  24  mantissa of operand B
- out_valid  out  1  aligned result valid
- out_ready  in  1  consumer accepts result
- exp_out  out  8  larger exponent
- man_big  out  24  mantissa of the larger-exponent operand, unshifted
- man_small  out  27  aligned smaller mantissa; [26:3] mantissa, [2] guard, [1] round, [0] sticky
- swapped  out  1  1 when B has the larger exponent
- shift_amt  out  8  raw exponent difference (not saturated)

Behaviour:
- Reset: state=IDLE; exp_out, man_big, man_small, swapped, shift_amt = 0; out_valid=0; in_ready=0 while rst=1. Reset mid-operation aborts the operation with no output.
- FSM states: IDLE, SHIFT, DONE. in_ready=1 only in IDLE with rst=0. out_valid=1 only in DONE.
- IDLE, on in_valid&&in_ready:
  - If exp_a>=exp_b: big=A, swapped=0. Otherwise big=B, swapped=1. Ties select A.
  - Load shift_amt=|exp_a-exp_b|, exp_out=max exponent, man_big=big mantissa.
  - Load small register = {small mantissa, 3'b000}; remaining = min(shift_amt, SAT).
  - Next state: DONE if remaining==0, else SHIFT.
- SHIFT, each cycle:
  - k = min(STEP, remaining).
  - r <= {k zeros, r[26:k]}, with new r[0] = r[k] | OR(r[k-1:0]). The existing sticky is preserved.
  - remaining -= k; go to DONE when remaining reaches 0.
- DONE:
  - Outputs held stable while out_ready=0.
  - On out_ready=1: out_valid falls next cycle, state returns to IDLE. Output registers keep their last values.
- Latency from the accept edge to the first out_valid cycle: 1 + ceil(min(diff,SAT)/STEP) cycles.
- Throughput: one operation in flight. No new operand is accepted until the DONE handshake completes.
- in_valid while not in IDLE is ignored; the operands are not captured.
- diff>=SAT: man_small = 27'h0000001 if the small mantissa is nonzero, else 0.
- Zero mantissas shift normally; no special-case handling (NaN/Inf/denormal classification happens upstream).

Test Plan:
- Equal exponents: exp_a=exp_b=127, man_a=0x800000, man_b=0xA00000. Required: swapped=0, man_small=0x5000000, shift_amt=0, out_valid one cycle after accept.
- Small shift: exp_a=130, man_a=0x800000, exp_b=128, man_b=0xC00000. Required: exp_out=130, man_small=0x1800000, sticky=0, latency 2.
- Sticky generation: exp_a=150, man_a=0x800000, exp_b=140, man_b=0x800001. Required: man_small=0x0010001, latency 4.
- Swap and saturation: exp_a=20, man_a=0x800000, exp_b=220, man_b=0xFFFFFF. Required: swapped=1, exp_out=220, man_big=0xFFFFFF, shift_amt=200, man_small=0x0000001, latency 8.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands. Required: outputs stable, in_ready=0, new operands not captured; after out_ready=1, in_ready=1 the next cycle.
- Reset mid-SHIFT: start diff=20, assert rst for 1 cycle during SHIFT. Required: out_valid never asserts, all outputs 0, in_ready=1 the cycle after rst falls, and the next operation completes correctly.
